// File: rtl/sync_fifo_pkg.sv
// sync_fifo_pkg: default sizes, level type and configuration check for sync_fifo_prog
package sync_fifo_pkg;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_ADDR = 4;
  localparam int DEF_DEPTH = 16;
  localparam int DEF_AFULL_TH = 12;
  localparam int DEF_AEMPTY_TH = 4;
  typedef logic [DEF_ADDR:0] level_t;
  function automatic bit cfg_ok(int addr, int depth, int afull_th, int aempty_th);
    return depth == (1 << addr) && afull_th >= 1 && afull_th <= depth &&
           aempty_th >= 0 && aempty_th < depth;
  endfunction
endpackage

// File: rtl/sync_fifo_prog_if.sv
// sync_fifo_prog_if: write/read handshake, status and error signals of sync_fifo_prog
//   master drives i_winc/i_WR_Data/i_rinc/i_clr_err and observes the o_* outputs;
//   slave (the FIFO) is the reverse.
interface sync_fifo_prog_if import sync_fifo_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int ADDR = DEF_ADDR
) ();
  logic i_winc;
  logic [WIDTH-1:0] i_WR_Data;
  logic i_rinc;
  logic i_clr_err;
  logic [WIDTH-1:0] o_RD_Data;
  logic o_wfull;
  logic o_rempty;
  logic o_afull;
  logic o_aempty;
  logic [ADDR:0] o_level;
  logic o_ovf;
  logic o_udf;
  modport master (
    output i_winc, i_WR_Data, i_rinc, i_clr_err,
    input o_RD_Data, o_wfull, o_rempty, o_afull, o_aempty, o_level, o_ovf, o_udf
  );
  modport slave (
    input i_winc, i_WR_Data, i_rinc, i_clr_err,
    output o_RD_Data, o_wfull, o_rempty, o_afull, o_aempty, o_level, o_ovf, o_udf
  );
endinterface

// File: rtl/fifo_mem.sv
// fifo_mem: DEPTH x WIDTH register array, one synchronous write port, one asynchronous read port
//   clk, we/waddr/wdata (write), raddr -> rdata (read). Contents are not reset.
module fifo_mem #(
  parameter int WIDTH = 8,
  parameter int ADDR = 4,
  parameter int DEPTH = 16
) (
  input  logic clk,
  input  logic we,
  input  logic [ADDR-1:0] waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [ADDR-1:0] raddr,
  output logic [WIDTH-1:0] rdata
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end
  assign rdata = mem_q[raddr];
endmodule

// File: rtl/sync_fifo_prog.sv
// sync_fifo_prog: single-clock FIFO with level, programmable almost flags and sticky ovf/udf
//   i_clk, i_rst (sync, active-high), bus (sync_fifo_prog_if.slave): write/read requests,
//   error clear, read data, full/empty/almost flags, level, overflow/underflow.
//   Define SYNC_FIFO_FWFT_EN for a first-word-fall-through read port; default is a
//   registered read port with 1-cycle latency.
module sync_fifo_prog import sync_fifo_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int ADDR = DEF_ADDR,
  parameter int DEPTH = DEF_DEPTH,
  parameter int AFULL_TH = DEF_AFULL_TH,
  parameter int AEMPTY_TH = DEF_AEMPTY_TH
) (
  input logic i_clk,
  input logic i_rst,
  sync_fifo_prog_if.slave bus
);
  if (!cfg_ok(ADDR, DEPTH, AFULL_TH, AEMPTY_TH)) begin : g_cfg_err
    $error("sync_fifo_prog: DEPTH must be 2**ADDR and thresholds in range");
  end
  localparam logic [ADDR:0] ONE = {{ADDR{1'b0}}, 1'b1};
  localparam logic [ADDR:0] FULL_LVL = {1'b1, {ADDR{1'b0}}};
  localparam logic [ADDR:0] AF_LVL = (ADDR+1)'(AFULL_TH);
  localparam logic [ADDR:0] AE_LVL = (ADDR+1)'(AEMPTY_TH);
  logic [ADDR:0] wptr_q, wptr_d, rptr_q, rptr_d, level_q, level_d;
  logic ovf_q, ovf_d, udf_q, udf_d, full, empty, we, re;
  logic [WIDTH-1:0] mem_rd;
  // Flags decode from the registered level only, so they never glitch.
  always_comb begin
    full = level_q == FULL_LVL;
    empty = level_q == '0;
    we = bus.i_winc && !full;
    re = bus.i_rinc && !empty;
    wptr_d = we ? wptr_q + ONE : wptr_q;
    rptr_d = re ? rptr_q + ONE : rptr_q;
    level_d = (we && !re) ? level_q + ONE : (re && !we) ? level_q - ONE : level_q;
    ovf_d = (bus.i_winc && full) || (ovf_q && !bus.i_clr_err);
    udf_d = (bus.i_rinc && empty) || (udf_q && !bus.i_clr_err);
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      level_q <= '0;
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      level_q <= level_d;
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end
  fifo_mem #(.WIDTH(WIDTH), .ADDR(ADDR), .DEPTH(DEPTH)) u_mem (
    .clk(i_clk),
    .we(we && !i_rst),
    .waddr(wptr_q[ADDR-1:0]),
    .wdata(bus.i_WR_Data),
    .raddr(rptr_q[ADDR-1:0]),
    .rdata(mem_rd)
  );
`ifdef SYNC_FIFO_FWFT_EN
  assign bus.o_RD_Data = mem_rd;
`else
  logic [WIDTH-1:0] rd_data_q, rd_data_d;
  always_comb rd_data_d = re ? mem_rd : rd_data_q;
  always_ff @(posedge i_clk) begin
    if (i_rst) rd_data_q <= '0;
    else rd_data_q <= rd_data_d;
  end
  assign bus.o_RD_Data = rd_data_q;
`endif
  assign bus.o_wfull = full;
  assign bus.o_rempty = empty;
  assign bus.o_afull = level_q >= AF_LVL;
  assign bus.o_aempty = level_q <= AE_LVL;
  assign bus.o_level = level_q;
  assign bus.o_ovf = ovf_q;
  assign bus.o_udf = udf_q;
endmodule

// File: tb/tb_sync_fifo_prog.sv
// tb_sync_fifo_prog: randomized and directed checks of sync_fifo_prog against a queue model
module tb_sync_fifo_prog;
  import sync_fifo_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int n_tests = 0;
  int n_fail = 0;
  logic [7:0] mq[$];
  bit m_ovf, m_udf;
  logic [7:0] m_rd;
  sync_fifo_prog_if #(.WIDTH(8), .ADDR(4)) bus ();
  sync_fifo_prog dut (.i_clk(clk), .i_rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;

  task automatic tick(input bit w, input logic [7:0] d, input bit r, input bit c, input bit rs);
    bit full, empty;
    bus.i_winc = w;
    bus.i_WR_Data = d;
    bus.i_rinc = r;
    bus.i_clr_err = c;
    rst = rs;
    @(posedge clk);
    if (rs) begin
      mq.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
      m_rd = 8'h00;
    end else begin
      full = mq.size() == 16;
      empty = mq.size() == 0;
      if (r && !empty) m_rd = mq.pop_front();
      if (w && !full) mq.push_back(d);
      m_ovf = (w && full) ? 1'b1 : c ? 1'b0 : m_ovf;
      m_udf = (r && empty) ? 1'b1 : c ? 1'b0 : m_udf;
    end
    #1;
    bus.i_winc = 1'b0;
    bus.i_rinc = 1'b0;
    bus.i_clr_err = 1'b0;
    rst = 1'b0;
  endtask

  function automatic bit data_known();
`ifdef SYNC_FIFO_FWFT_EN
    return mq.size() != 0;
`else
    return 1'b1;
`endif
  endfunction

  function automatic logic [7:0] exp_data();
`ifdef SYNC_FIFO_FWFT_EN
    return mq.size() != 0 ? mq[0] : 8'h00;
`else
    return m_rd;
`endif
  endfunction

  task automatic test_reset();
    tick(0, 8'h00, 0, 0, 1);
    n_tests++; if (bus.o_level !== 5'd0) begin n_fail++; $display("FAIL reset_level: got %0d exp 0", bus.o_level); end
    n_tests++; if (bus.o_rempty !== 1'b1) begin n_fail++; $display("FAIL reset_rempty: got %b exp 1", bus.o_rempty); end
    n_tests++; if (bus.o_aempty !== 1'b1) begin n_fail++; $display("FAIL reset_aempty: got %b exp 1", bus.o_aempty); end
    n_tests++; if (bus.o_wfull !== 1'b0) begin n_fail++; $display("FAIL reset_wfull: got %b exp 0", bus.o_wfull); end
    n_tests++; if (bus.o_afull !== 1'b0) begin n_fail++; $display("FAIL reset_afull: got %b exp 0", bus.o_afull); end
    n_tests++; if (bus.o_ovf !== 1'b0 || bus.o_udf !== 1'b0) begin n_fail++; $display("FAIL reset_err: got ovf=%b udf=%b exp 0 0", bus.o_ovf, bus.o_udf); end
`ifndef SYNC_FIFO_FWFT_EN
    n_tests++; if (bus.o_RD_Data !== 8'h00) begin n_fail++; $display("FAIL reset_rd: got %h exp 00", bus.o_RD_Data); end
`endif
  endtask

  task automatic test_fill();
    for (int i = 0; i < 16; i++) begin
      tick(1, 8'(8'h11 + i), 0, 0, 0);
      n_tests++; if (bus.o_afull !== (i + 1 >= 12)) begin n_fail++; $display("FAIL fill_afull: write %0d got %b exp %b", i + 1, bus.o_afull, i + 1 >= 12); end
      n_tests++; if (bus.o_wfull !== (i + 1 == 16)) begin n_fail++; $display("FAIL fill_wfull: write %0d got %b exp %b", i + 1, bus.o_wfull, i + 1 == 16); end
      n_tests++; if (bus.o_rempty !== 1'b0) begin n_fail++; $display("FAIL fill_rempty: write %0d got %b exp 0", i + 1, bus.o_rempty); end
    end
    n_tests++; if (bus.o_level !== 5'd16) begin n_fail++; $display("FAIL fill_level: got %0d exp 16", bus.o_level); end
    n_tests++; if (bus.o_ovf !== 1'b0) begin n_fail++; $display("FAIL fill_ovf: got %b exp 0", bus.o_ovf); end
  endtask

  task automatic test_overflow();
    tick(1, 8'hAA, 0, 0, 0);
    n_tests++; if (bus.o_ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_set: got %b exp 1", bus.o_ovf); end
    n_tests++; if (bus.o_level !== 5'd16) begin n_fail++; $display("FAIL ovf_level: got %0d exp 16", bus.o_level); end
    tick(0, 8'h00, 0, 1, 0);
    n_tests++; if (bus.o_ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_clr: got %b exp 0", bus.o_ovf); end
    tick(1, 8'hAA, 0, 1, 0);
    n_tests++; if (bus.o_ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_set_beats_clr: got %b exp 1", bus.o_ovf); end
    tick(0, 8'h00, 0, 1, 0);
    n_tests++; if (bus.o_ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_clr2: got %b exp 0", bus.o_ovf); end
  endtask

  task automatic test_drain();
    for (int i = 0; i < 16; i++) begin
`ifdef SYNC_FIFO_FWFT_EN
      n_tests++; if (bus.o_RD_Data !== 8'(8'h11 + i)) begin n_fail++; $display("FAIL drain_data: read %0d got %h exp %h", i, bus.o_RD_Data, 8'(8'h11 + i)); end
`endif
      tick(0, 8'h00, 1, 0, 0);
`ifndef SYNC_FIFO_FWFT_EN
      n_tests++; if (bus.o_RD_Data !== 8'(8'h11 + i)) begin n_fail++; $display("FAIL drain_data: read %0d got %h exp %h", i, bus.o_RD_Data, 8'(8'h11 + i)); end
`endif
      n_tests++; if (bus.o_aempty !== (15 - i <= 4)) begin n_fail++; $display("FAIL drain_aempty: level %0d got %b exp %b", 15 - i, bus.o_aempty, 15 - i <= 4); end
      n_tests++; if (bus.o_rempty !== (i == 15)) begin n_fail++; $display("FAIL drain_rempty: read %0d got %b exp %b", i, bus.o_rempty, i == 15); end
    end
    tick(0, 8'h00, 1, 0, 0);
    n_tests++; if (bus.o_udf !== 1'b1) begin n_fail++; $display("FAIL udf_set: got %b exp 1", bus.o_udf); end
    n_tests++; if (bus.o_level !== 5'd0) begin n_fail++; $display("FAIL udf_level: got %0d exp 0", bus.o_level); end
`ifndef SYNC_FIFO_FWFT_EN
    n_tests++; if (bus.o_RD_Data !== 8'h20) begin n_fail++; $display("FAIL udf_rd_hold: got %h exp 20", bus.o_RD_Data); end
`endif
    tick(1, 8'h99, 1, 0, 0);
    n_tests++; if (bus.o_udf !== 1'b1 || bus.o_level !== 5'd1) begin n_fail++; $display("FAIL udf_write_same_edge: got udf=%b level=%0d exp 1 1", bus.o_udf, bus.o_level); end
    tick(0, 8'h00, 1, 1, 0);
    n_tests++; if (bus.o_udf !== 1'b0 || bus.o_RD_Data !== 8'h99) begin n_fail++; $display("FAIL udf_clr: got udf=%b rd=%h exp 0 99", bus.o_udf, bus.o_RD_Data); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 5; i++) tick(1, 8'(8'h30 + i), 0, 0, 0);
    for (int i = 0; i < 40; i++) begin
      tick(1, 8'(8'h35 + i), 1, 0, 0);
      n_tests++; if (bus.o_level !== 5'd5) begin n_fail++; $display("FAIL b2b_level: cycle %0d got %0d exp 5", i, bus.o_level); end
      n_tests++; if (bus.o_RD_Data !== exp_data()) begin n_fail++; $display("FAIL b2b_data: cycle %0d got %h exp %h", i, bus.o_RD_Data, exp_data()); end
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) tick(1, 8'(8'h60 + i), 0, 0, 0);
    n_tests++; if (bus.o_level !== 5'd8) begin n_fail++; $display("FAIL rstmid_pre_level: got %0d exp 8", bus.o_level); end
    tick(1, 8'h77, 0, 0, 1);
    n_tests++; if (bus.o_level !== 5'd0 || bus.o_rempty !== 1'b1) begin n_fail++; $display("FAIL rstmid_state: got level=%0d rempty=%b exp 0 1", bus.o_level, bus.o_rempty); end
    tick(1, 8'h3C, 0, 0, 0);
`ifdef SYNC_FIFO_FWFT_EN
    n_tests++; if (bus.o_RD_Data !== 8'h3C) begin n_fail++; $display("FAIL rstmid_data: got %h exp 3c", bus.o_RD_Data); end
`endif
    tick(0, 8'h00, 1, 0, 0);
`ifndef SYNC_FIFO_FWFT_EN
    n_tests++; if (bus.o_RD_Data !== 8'h3C) begin n_fail++; $display("FAIL rstmid_data: got %h exp 3c", bus.o_RD_Data); end
`endif
    n_tests++; if (bus.o_rempty !== 1'b1) begin n_fail++; $display("FAIL rstmid_empty: got %b exp 1", bus.o_rempty); end
  endtask

  task automatic test_fwft_write();
    tick(1, 8'h5C, 0, 0, 0);
    n_tests++; if (bus.o_rempty !== 1'b0) begin n_fail++; $display("FAIL fwft_rempty: got %b exp 0", bus.o_rempty); end
`ifdef SYNC_FIFO_FWFT_EN
    n_tests++; if (bus.o_RD_Data !== 8'h5C) begin n_fail++; $display("FAIL fwft_data: got %h exp 5c", bus.o_RD_Data); end
`else
    n_tests++; if (bus.o_RD_Data !== 8'h3C) begin n_fail++; $display("FAIL std_no_early_data: got %h exp 3c", bus.o_RD_Data); end
`endif
    tick(0, 8'h00, 1, 0, 0);
`ifndef SYNC_FIFO_FWFT_EN
    n_tests++; if (bus.o_RD_Data !== 8'h5C) begin n_fail++; $display("FAIL std_data: got %h exp 5c", bus.o_RD_Data); end
`endif
  endtask

  task automatic test_random();
    level_t lv;
    bit w, r, c, rs;
    for (int i = 0; i < 400; i++) begin
      w = $urandom_range(99) < (((i / 50) % 2) ? 80 : 30);
      r = $urandom_range(99) < (((i / 50) % 2) ? 30 : 75);
      c = $urandom_range(15) == 0;
      rs = $urandom_range(99) == 0;
      tick(w, 8'($urandom), r, c, rs);
      lv = level_t'(mq.size());
      n_tests++; if (bus.o_level !== lv) begin n_fail++; $display("FAIL rnd_level: cycle %0d got %0d exp %0d", i, bus.o_level, lv); end
      n_tests++; if (bus.o_wfull !== (lv == 16)) begin n_fail++; $display("FAIL rnd_wfull: cycle %0d got %b exp %b", i, bus.o_wfull, lv == 16); end
      n_tests++; if (bus.o_rempty !== (lv == 0)) begin n_fail++; $display("FAIL rnd_rempty: cycle %0d got %b exp %b", i, bus.o_rempty, lv == 0); end
      n_tests++; if (bus.o_afull !== (lv >= 12)) begin n_fail++; $display("FAIL rnd_afull: cycle %0d got %b exp %b", i, bus.o_afull, lv >= 12); end
      n_tests++; if (bus.o_aempty !== (lv <= 4)) begin n_fail++; $display("FAIL rnd_aempty: cycle %0d got %b exp %b", i, bus.o_aempty, lv <= 4); end
      n_tests++; if (bus.o_ovf !== m_ovf || bus.o_udf !== m_udf) begin n_fail++; $display("FAIL rnd_err: cycle %0d got ovf=%b udf=%b exp %b %b", i, bus.o_ovf, bus.o_udf, m_ovf, m_udf); end
      if (data_known()) begin
        n_tests++; if (bus.o_RD_Data !== exp_data()) begin n_fail++; $display("FAIL rnd_data: cycle %0d got %h exp %h", i, bus.o_RD_Data, exp_data()); end
      end
    end
  endtask

  initial begin
    bus.i_winc = 1'b0;
    bus.i_WR_Data = 8'h00;
    bus.i_rinc = 1'b0;
    bus.i_clr_err = 1'b0;
    m_rd = 8'h00;
    test_reset();
    test_fill();
    test_overflow();
    test_drain();
    test_back_to_back();
    test_reset_mid();
    test_fwft_write();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
